// File: rtl/pixel_bank_scheduler.sv
// -----------------------------------------------------------------------------
// pixel_bank_scheduler
//
// Ping-pong style pixel buffer for the k-means datapath. One image is captured
// round-robin into LANES independent banks. It is then replayed to LANES
// cluster engines in parallel, once per start_pass, with no reload between
// passes.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   valid         in   pixel_in carries a pixel this cycle
//   end_of_image  in   last pixel of the image (may coincide with valid)
//   pixel_in      in   incoming pixel, PIX_W bits
//   in_ready      out  block accepts pixels (FILL and not full)
//   start_pass    in   pulse: begin one replay pass (honoured in LOADED)
//   clear         in   pulse: discard the image, return to FILL
//   lane_valid    out  per-lane output valid, LANES bits
//   lane_pixel    out  per-lane pixel, lane l at [l*PIX_W +: PIX_W]
//   pass_done     out  one-cycle pulse at the end of each pass
//   loaded        out  image stored, waiting for start_pass
//   overflow      out  sticky: a pixel was dropped because all banks were full
//   pixel_count   out  total pixels stored
//   pass_count    out  passes completed since the last load (wraps)
// -----------------------------------------------------------------------------
module pixel_bank_scheduler #(
  parameter int LANES  = 2,
  parameter int PIX_W  = 24,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int PASS_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     end_of_image,
  input  logic [PIX_W-1:0]         pixel_in,
  output logic                     in_ready,
  input  logic                     start_pass,
  input  logic                     clear,
  output logic [LANES-1:0]         lane_valid,
  output logic [LANES*PIX_W-1:0]   lane_pixel,
  output logic                     pass_done,
  output logic                     loaded,
  output logic                     overflow,
  output logic [ADDR_W+4:0]        pixel_count,
  output logic [PASS_W-1:0]        pass_count
);

  localparam int          FILL_W = ADDR_W + 1;   // a full bank (DEPTH) fits
  localparam int          CNT_W  = ADDR_W + 5;
  localparam int          SEL_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CAP    = LANES * DEPTH;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LOADED = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e              state_q;
  logic [FILL_W-1:0]   fill_q [LANES];
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_d;
  logic [CNT_W-1:0]    pixel_count_q;
  logic                overflow_q;
  logic [PASS_W-1:0]   pass_count_q;
  logic [FILL_W-1:0]   rd_addr_q;
  logic [LANES-1:0]    lane_valid_q;
  logic                pass_done_q;

  logic                accept;
  logic                stream_active;
  logic [LANES-1:0]    rd_hit;
  logic [LANES-1:0]    wr_en;
  logic [LANES-1:0]    rd_en;

  // ---------------------------------------------------------------------------
  // Decoded status. in_ready is only ever high in FILL, so an accepted pixel
  // always targets a bank that still has room (round-robin keeps fills level).
  // ---------------------------------------------------------------------------
  assign in_ready      = (state_q == S_FILL) && (pixel_count_q < CNT_W'(CAP));
  assign loaded        = (state_q == S_LOADED);
  assign accept        = valid && in_ready && !clear;
  // Lane 0 always holds the most pixels, so its fill sets the pass length.
  assign stream_active = (state_q == S_STREAM) && (rd_addr_q < fill_q[0]);

  assign sel_d = (sel_q == SEL_W'(LANES - 1)) ? '0 : sel_q + SEL_W'(1);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rd_hit = '0;
    wr_en  = '0;
    rd_en  = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_hit[l] = (rd_addr_q < fill_q[l]);
      wr_en[l]  = accept && (sel_q == SEL_W'(l));
      rd_en[l]  = stream_active && !clear && rd_hit[l];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. The stream side issues one read address per cycle; the bank
  // output register lands one edge later, so lane_valid is registered here in
  // the same edge as that data capture.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FILL;
      for (int l = 0; l < LANES; l++) fill_q[l] <= '0;
      sel_q         <= '0;
      pixel_count_q <= '0;
      overflow_q    <= 1'b0;
      pass_count_q  <= '0;
      rd_addr_q     <= '0;
      lane_valid_q  <= '0;
      pass_done_q   <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      if (clear) begin
        // Discard everything; an in-flight pass ends without pass_done.
        state_q       <= S_FILL;
        for (int l = 0; l < LANES; l++) fill_q[l] <= '0;
        sel_q         <= '0;
        pixel_count_q <= '0;
        overflow_q    <= 1'b0;
        pass_count_q  <= '0;
        rd_addr_q     <= '0;
        lane_valid_q  <= '0;
      end else begin
        unique case (state_q)
          S_FILL: begin
            if (accept) begin
              fill_q[sel_q] <= fill_q[sel_q] + FILL_W'(1);
              sel_q         <= sel_d;
              pixel_count_q <= pixel_count_q + CNT_W'(1);
            end else if (valid) begin
              overflow_q <= 1'b1;
            end
            // A pixel arriving with end_of_image is stored above first.
            if (end_of_image) state_q <= S_LOADED;
          end
          S_LOADED: begin
            if (start_pass) begin
              state_q   <= S_STREAM;
              rd_addr_q <= '0;
            end
          end
          S_STREAM: begin
            if (stream_active) begin
              lane_valid_q <= rd_hit;
              rd_addr_q    <= rd_addr_q + FILL_W'(1);
            end else begin
              // One cycle after the last data beat: close the pass.
              lane_valid_q <= '0;
              pass_done_q  <= 1'b1;
              pass_count_q <= pass_count_q + PASS_W'(1);
              state_q      <= S_LOADED;
            end
          end
          default: state_q <= S_FILL;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Banks: simple dual-port RAM per lane. Writes only happen in FILL and reads
  // only in STREAM, so a bank never sees both in the same cycle.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_bank
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_q;

    // NOTE: the storage array has no reset so it maps onto block RAM; its
    // contents are meaningless until written during FILL.
    always_ff @(posedge clk) begin
      if (wr_en[g]) mem[fill_q[g][ADDR_W-1:0]] <= pixel_in;
    end

    // Read register holds its value while the lane is idle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)        rd_q <= '0;
      else if (rd_en[g]) rd_q <= mem[rd_addr_q[ADDR_W-1:0]];
    end

    assign lane_pixel[g*PIX_W +: PIX_W] = rd_q;
  end

  assign lane_valid  = lane_valid_q;
  assign pass_done   = pass_done_q;
  assign overflow    = overflow_q;
  assign pixel_count = pixel_count_q;
  assign pass_count  = pass_count_q;

endmodule
